hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W).
- Generates stall and flush controls for load-use hazards and ID-stage branch-operand hazards.
- Sequences the multi-cycle multiply/divide unit and its HI/LO write.
- Works alongside the EXE forwarding unit: it covers every hazard that forwarding cannot resolve.

Parameters:
- MUL_LAT, 4, cycles from the mult start cycle to the HI/LO write cycle (min 2).
- DIV_LAT, 32, cycles from the div start cycle to the HI/LO write cycle (min 2).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- RA1_D  in  5  ID rs address.
- RA2_D  in  5  ID rt address.
- use1_D  in  1  ID instruction reads RA1.
- use2_D  in  1  ID instruction reads RA2.
- branch_D  in  1  ID instruction is a branch compared in ID.
- pc_redir_D  in  1  branch taken or jump in ID.
- hilo_rd_D  in  1  mfhi/mflo in ID.
- md_D  in  1  mult/div in ID.
- WA_E  in  5  EX destination register.
- WE_E  in  1  EX register write enable.
- load_E  in  1  EX instruction is a load.
- md_start_E  in  1  mult/div in EX; one-cycle start request.
- md_div_E  in  1  1 = div, 0 = mult.
- WA_M  in  5  MEM destination register.
- WE_M  in  1  MEM register write enable.
- load_M  in  1  MEM instruction is a load.
- stall_F  out  1  hold PC.
- stall_D  out  1  hold IF/ID register.
- flush_E  out  1  insert a bubble into ID/EX.
- flush_D  out  1  squash IF/ID.
- md_busy  out  1  mult/div in progress.
- hilo_we  out  1  HI/LO write strobe.
- md_err  out  1  sticky protocol error.
- stall_cnt  out  32  stall-cycle count (optional feature).
- flush_cnt  out  32  flush_D count (optional feature).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - FSM goes to IDLE; cnt=0; md_err=0; counters=0.
  - While rst_n=0, every output is forced to 0.
- Hazard terms (combinational). A match requires the addresses equal, the matching use bit set and the address != 0.
  - lu: load_E & WE_E & WA_E matches RA1_D or RA2_D.
  - br: branch_D & [(WE_E & WA_E match) | (load_M & WE_M & WA_M match)].
  - mdb: (hilo_rd_D | md_D) & busy_eff, where busy_eff = (state==BUSY) | (state==IDLE & md_start_E).
- stall = lu | br | mdb.
  - When stall=1: stall_F = stall_D = flush_E = 1.
- flush_D = pc_redir_D & ~stall. Stall has priority, so a redirect is never taken while stalled.
- Multiply/divide sequencer FSM: states IDLE, BUSY, DONE.
  - IDLE + md_start_E: load cnt = (md_div_E ? DIV_LAT : MUL_LAT) - 1, then go to BUSY.
  - BUSY: if cnt==1 go to DONE, else cnt = cnt - 1.
  - DONE: hilo_we=1 for exactly one cycle, then go to IDLE.
  - Resulting timing: start in cycle t puts hilo_we in cycle t+LAT.
- md_busy = (state != IDLE).
- In DONE, ID-stage mfhi/mult is not stalled: HI/LO is written at the end of DONE, before that instruction reads it in EX.
- md_start_E in BUSY or DONE is ignored and sets md_err (sticky until reset).
- Reset mid-operation abandons the operation with no hilo_we pulse.
- Counters wrap at 2^32 - 1 back to 0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with flush_D=1.
  - Both reset to 0.
- Undefined: both ports are tied to 32'd0 and no counter flops are built.
- Ports are present in both builds.

Decomposition:
- Shared header `hazard_defs.vh`:
  - FSM state localparams (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - Register-zero constant REG_ZERO = 5'd0.
- Sub-module `md_sequencer`:
  - Contains the FSM, cnt and md_err.
  - Outputs md_busy, hilo_we and busy_eff.
- The top level holds the combinational hazard logic and the optional counters.

Test Plan:
- Load-use: load_E=1, WE_E=1, WA_E=8, RA2_D=8, use2_D=1 -> stall_F = stall_D = flush_E = 1 for one cycle. With WA_E=0 -> all 0.
- Branch dependence:
  - branch_D=1, RA1_D=5, WE_E=1, WA_E=5 -> stall.
  - Next cycle, load_M=1, WE_M=1, WA_M=5 -> stall again.
  - pc_redir_D=1 during either stall -> flush_D=0.
- Mult timing, MUL_LAT=4:
  - md_start_E pulse in cycle 0 -> md_busy=1 in cycles 1-4; hilo_we=1 only in cycle 4.
  - hilo_rd_D=1 held -> stalled in cycles 0-3, released in cycle 4.
- Div, DIV_LAT=32: hilo_we exactly 32 cycles after start. A second md_start_E in cycle 10 -> md_err=1 and the timing is unchanged.
- Reset in cycle 2 of a mult -> the FSM is IDLE after the edge, hilo_we never pulses, all outputs are 0 while rst_n=0.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls plus 2 redirects -> stall_cnt=3, flush_cnt=2. Without the macro -> both 0.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - md_state_e : multiply/divide sequencer states (IDLE=0, BUSY=1, DONE=2)
//   - REG_ZERO   : architectural register $0, which never carries a dependence
//   - reg_match  : producer/consumer register dependence test
// -----------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // A write to $0 is discarded by the register file, so it never creates a
  // dependence even when the addresses compare equal.
  function automatic logic reg_match(input logic [4:0] wa,
                                     input logic [4:0] ra,
                                     input logic       rd_en);
    return rd_en && (wa == ra) && (wa != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_sequencer.sv
// -----------------------------------------------------------------------------
// md_sequencer
// Sequences the multi-cycle multiply/divide unit. A start in cycle t produces
// the HI/LO write strobe in cycle t+LAT (LAT = MUL_LAT or DIV_LAT).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   md_start_i   : one-cycle start request from EX
//   md_div_i     : 1 = divide, 0 = multiply
//   md_busy_o    : operation in progress (state != IDLE)
//   hilo_we_o    : HI/LO write strobe (DONE state)
//   busy_eff_o   : HI/LO not yet usable by an ID-stage consumer
//   md_err_o     : sticky error, start requested while not IDLE
// -----------------------------------------------------------------------------
module md_sequencer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start_i,
  input  logic md_div_i,
  output logic md_busy_o,
  output logic hilo_we_o,
  output logic busy_eff_o,
  output logic md_err_o
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  // cnt only ever holds LAT-1 at most.
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    hilo_we_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_start_i) begin
          cnt_d   = md_div_i ? DIV_LOAD : MUL_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_ONE) state_d = DONE;
        else                  cnt_d   = cnt_q - CNT_ONE;
        // A second start cannot be accepted; it is dropped and flagged.
        if (md_start_i) err_d = 1'b1;
      end
      DONE: begin
        hilo_we_o = 1'b1;
        state_d   = IDLE;
        if (md_start_i) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign md_busy_o  = (state_q != IDLE);
  // DONE is excluded: HI/LO is written at the end of DONE, before an ID-stage
  // reader reaches EX. A start in EX this cycle already blocks the reader.
  assign busy_eff_o = (state_q == BUSY) || ((state_q == IDLE) && md_start_i);
  assign md_err_o   = err_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Hazard controller for the 5-stage MIPS pipeline. Covers every hazard that
// EX forwarding cannot resolve: load-use, ID-stage branch operands, and HI/LO
// consumers while the multiply/divide unit is running.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   RA1_D/RA2_D, use1_D/use2_D : ID source registers and their read enables
//   branch_D, pc_redir_D       : ID branch compare / taken redirect
//   hilo_rd_D, md_D            : ID mfhi/mflo, ID mult/div
//   WA_E, WE_E, load_E         : EX destination, write enable, load flag
//   md_start_E, md_div_E       : EX mult/div start and kind
//   WA_M, WE_M, load_M         : MEM destination, write enable, load flag
//   stall_F, stall_D, flush_E  : stall front end and bubble ID/EX
//   flush_D                    : squash IF/ID on a redirect
//   md_busy, hilo_we, md_err   : mult/div sequencer status
//   stall_cnt, flush_cnt       : performance counters
// Build option: define HAZARD_PERF_CNT_EN to build the performance counters;
// otherwise both counter ports are tied to zero.
// All outputs read 0 while rst_n is low.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  RA1_D,
  input  logic [4:0]  RA2_D,
  input  logic        use1_D,
  input  logic        use2_D,
  input  logic        branch_D,
  input  logic        pc_redir_D,
  input  logic        hilo_rd_D,
  input  logic        md_D,
  input  logic [4:0]  WA_E,
  input  logic        WE_E,
  input  logic        load_E,
  input  logic        md_start_E,
  input  logic        md_div_E,
  input  logic [4:0]  WA_M,
  input  logic        WE_M,
  input  logic        load_M,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_E,
  output logic        flush_D,
  output logic        md_busy,
  output logic        hilo_we,
  output logic        md_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic hit_e, hit_m;
  logic lu, br, mdb, stall, redirect;
  logic busy_eff, md_busy_raw, hilo_we_raw, md_err_raw;

  md_sequencer #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .md_start_i (md_start_E),
    .md_div_i   (md_div_E),
    .md_busy_o  (md_busy_raw),
    .hilo_we_o  (hilo_we_raw),
    .busy_eff_o (busy_eff),
    .md_err_o   (md_err_raw)
  );

  assign hit_e = reg_match(WA_E, RA1_D, use1_D) | reg_match(WA_E, RA2_D, use2_D);
  assign hit_m = reg_match(WA_M, RA1_D, use1_D) | reg_match(WA_M, RA2_D, use2_D);

  // Load data is not available for forwarding until after MEM.
  assign lu  = load_E & WE_E & hit_e;
  // Branches compare in ID, ahead of the EX forwarding path: any EX producer
  // blocks them, and so does a load still sitting in MEM.
  assign br  = branch_D & ((WE_E & hit_e) | (load_M & WE_M & hit_m));
  assign mdb = (hilo_rd_D | md_D) & busy_eff;

  assign stall    = lu | br | mdb;
  // The stalled branch is re-evaluated next cycle, so its redirect waits.
  assign redirect = pc_redir_D & ~stall;

  assign stall_F = rst_n & stall;
  assign stall_D = rst_n & stall;
  assign flush_E = rst_n & stall;
  assign flush_D = rst_n & redirect;
  assign md_busy = rst_n & md_busy_raw;
  assign hilo_we = rst_n & hilo_we_raw;
  assign md_err  = rst_n & md_err_raw;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Free-running counters; they wrap naturally at 2^32.
  assign stall_cnt_d = stall_cnt_q + {31'd0, stall};
  assign flush_cnt_d = flush_cnt_q + {31'd0, redirect};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = rst_n ? stall_cnt_q : 32'd0;
  assign flush_cnt = rst_n ? flush_cnt_q : 32'd0;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  RA1_D, RA2_D, WA_E, WA_M;
  logic        use1_D, use2_D, branch_D, pc_redir_D, hilo_rd_D, md_D;
  logic        WE_E, load_E, md_start_E, md_div_E, WE_M, load_M;
  logic        stall_F, stall_D, flush_E, flush_D, md_busy, hilo_we, md_err;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_stall_ctrl #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RA1_D      (RA1_D),
    .RA2_D      (RA2_D),
    .use1_D     (use1_D),
    .use2_D     (use2_D),
    .branch_D   (branch_D),
    .pc_redir_D (pc_redir_D),
    .hilo_rd_D  (hilo_rd_D),
    .md_D       (md_D),
    .WA_E       (WA_E),
    .WE_E       (WE_E),
    .load_E     (load_E),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .WA_M       (WA_M),
    .WE_M       (WE_M),
    .load_M     (load_M),
    .stall_F    (stall_F),
    .stall_D    (stall_D),
    .flush_E    (flush_E),
    .flush_D    (flush_D),
    .md_busy    (md_busy),
    .hilo_we    (hilo_we),
    .md_err     (md_err),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  typedef struct packed {
    logic        stall_F;
    logic        stall_D;
    logic        flush_E;
    logic        flush_D;
    logic        md_busy;
    logic        hilo_we;
    logic        md_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: the model tracks the mult/div operation only as
  // "the cycle number at which HI/LO gets written" (-1 = none outstanding).
  int          cyc     = 0;
  int          wr_cyc  = -1;
  bit          err_m   = 1'b0;
  logic [31:0] scnt_m  = 32'd0;
  logic [31:0] fcnt_m  = 32'd0;

  function automatic bit dep(input logic [4:0] wa, input logic [4:0] ra, input logic rd_en);
    return rd_en && (wa == ra) && (wa != 5'd0);
  endfunction

  // Compute the expected outputs for the inputs currently applied, queue them,
  // then advance the model across the coming clock edge.
  task automatic issue();
    obs_t e;
    bit   busy, blocks_hilo, lu, br, st, fl, hit_e, hit_m;
    e = '0;
    if (!rst_n) begin
      wr_cyc = -1;
      err_m  = 1'b0;
      scnt_m = 32'd0;
      fcnt_m = 32'd0;
    end else begin
      busy        = (wr_cyc >= 0) && (cyc <= wr_cyc);
      blocks_hilo = (busy && (cyc < wr_cyc)) || (!busy && md_start_E);
      hit_e = dep(WA_E, RA1_D, use1_D) || dep(WA_E, RA2_D, use2_D);
      hit_m = dep(WA_M, RA1_D, use1_D) || dep(WA_M, RA2_D, use2_D);
      lu    = load_E && WE_E && hit_e;
      br    = branch_D && ((WE_E && hit_e) || (load_M && WE_M && hit_m));
      st    = lu || br || ((hilo_rd_D || md_D) && blocks_hilo);
      fl    = pc_redir_D && !st;
      e.stall_F   = st;
      e.stall_D   = st;
      e.flush_E   = st;
      e.flush_D   = fl;
      e.md_busy   = busy;
      e.hilo_we   = busy && (cyc == wr_cyc);
      e.md_err    = err_m;
      e.stall_cnt = PERF ? scnt_m : 32'd0;
      e.flush_cnt = PERF ? fcnt_m : 32'd0;
      if (md_start_E) begin
        if (busy) err_m = 1'b1;
        else      wr_cyc = cyc + (md_div_E ? DIV_LAT : MUL_LAT);
      end
      scnt_m = scnt_m + {31'd0, st};
      fcnt_m = fcnt_m + {31'd0, fl};
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic tick();
    issue();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RA1_D = 5'd0; RA2_D = 5'd0; WA_E = 5'd0; WA_M = 5'd0;
    use1_D = 1'b0; use2_D = 1'b0; branch_D = 1'b0; pc_redir_D = 1'b0;
    hilo_rd_D = 1'b0; md_D = 1'b0; WE_E = 1'b0; load_E = 1'b0;
    md_start_E = 1'b0; md_div_E = 1'b0; WE_M = 1'b0; load_M = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a full output vector; compare it
  // mid-cycle against the oldest queued expectation.
  initial begin
    obs_t e, a;
    int   mcyc;
    mcyc = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{stall_F, stall_D, flush_E, flush_D, md_busy, hilo_we, md_err, stall_cnt, flush_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: got stF=%b stD=%b flE=%b flD=%b busy=%b we=%b err=%b scnt=%0d fcnt=%0d, expected stF=%b stD=%b flE=%b flD=%b busy=%b we=%b err=%b scnt=%0d fcnt=%0d",
                   mcyc, a.stall_F, a.stall_D, a.flush_E, a.flush_D, a.md_busy, a.hilo_we, a.md_err,
                   a.stall_cnt, a.flush_cnt, e.stall_F, e.stall_D, e.flush_E, e.flush_D, e.md_busy,
                   e.hilo_we, e.md_err, e.stall_cnt, e.flush_cnt);
        end
        mcyc++;
      end
    end
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    // Reset state.
    tick(); tick();
    rst_n = 1'b1;

    // Load-use on rt, then the same with $0 as destination.
    load_E = 1'b1; WE_E = 1'b1; WA_E = 5'd8; RA2_D = 5'd8; use2_D = 1'b1;
    tick();
    clear_inputs(); tick();
    load_E = 1'b1; WE_E = 1'b1; WA_E = 5'd0; RA2_D = 5'd0; use2_D = 1'b1;
    tick();
    clear_inputs();

    // Branch operand produced in EX, then by a load in MEM; redirect held.
    branch_D = 1'b1; RA1_D = 5'd5; use1_D = 1'b1; pc_redir_D = 1'b1;
    WE_E = 1'b1; WA_E = 5'd5;
    tick();
    WE_E = 1'b0; WA_E = 5'd0; load_M = 1'b1; WE_M = 1'b1; WA_M = 5'd5;
    tick();
    load_M = 1'b0; WE_M = 1'b0;
    tick();
    clear_inputs(); tick();

    // Multiply with an mfhi waiting in ID.
    md_start_E = 1'b1; hilo_rd_D = 1'b1;
    tick();
    md_start_E = 1'b0;
    repeat (5) tick();
    clear_inputs(); tick();

    // Divide with a rejected second start in cycle 10.
    md_start_E = 1'b1; md_div_E = 1'b1;
    tick();
    clear_inputs();
    repeat (9) tick();
    md_start_E = 1'b1; md_div_E = 1'b1;
    tick();
    clear_inputs();
    repeat (25) tick();

    // Reset in cycle 2 of a multiply.
    rst_n = 1'b0; tick();
    rst_n = 1'b1; md_start_E = 1'b1; tick();
    md_start_E = 1'b0; tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    repeat (6) tick();

    // Counter run from reset: three load-use stalls and two redirects.
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_E = 1'b1; WE_E = 1'b1; WA_E = 5'd3; RA1_D = 5'd3; use1_D = 1'b1;
      tick();
      clear_inputs(); tick();
    end
    for (int i = 0; i < 2; i++) begin
      pc_redir_D = 1'b1; tick();
      clear_inputs(); tick();
    end
    tick();

    // Randomised traffic with small address space to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(0, 149) != 0);
      RA1_D      = 5'($urandom_range(0, 3));
      RA2_D      = 5'($urandom_range(0, 3));
      WA_E       = 5'($urandom_range(0, 3));
      WA_M       = 5'($urandom_range(0, 3));
      use1_D     = 1'($urandom_range(0, 1));
      use2_D     = 1'($urandom_range(0, 1));
      branch_D   = 1'($urandom_range(0, 1));
      pc_redir_D = 1'($urandom_range(0, 1));
      hilo_rd_D  = ($urandom_range(0, 3) == 0);
      md_D       = ($urandom_range(0, 5) == 0);
      WE_E       = 1'($urandom_range(0, 1));
      load_E     = 1'($urandom_range(0, 1));
      WE_M       = 1'($urandom_range(0, 1));
      load_M     = 1'($urandom_range(0, 1));
      md_start_E = ($urandom_range(0, 11) == 0);
      md_div_E   = ($urandom_range(0, 3) == 0);
      tick();
    end
    clear_inputs();

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
